// File: rtl/map_port_arbiter_pkg.sv
// Shared widths, block id constants and write-sequencer state encoding for the
// map RAM port arbiter.
package map_port_arbiter_pkg;

  localparam int MAP_ADDR_W = 15;
  localparam int MAP_DATA_W = 4;

  localparam logic [MAP_DATA_W-1:0] BLK_AIR    = 4'd0;
  localparam logic [MAP_DATA_W-1:0] BLK_STONE  = 4'd1;
  localparam logic [MAP_DATA_W-1:0] BLK_DIRT   = 4'd2;
  localparam logic [MAP_DATA_W-1:0] BLK_GRASS  = 4'd3;
  localparam logic [MAP_DATA_W-1:0] BLK_SAND   = 4'd4;
  localparam logic [MAP_DATA_W-1:0] BLK_WATER  = 4'd5;
  localparam logic [MAP_DATA_W-1:0] BLK_WOOD   = 4'd6;
  localparam logic [MAP_DATA_W-1:0] BLK_LEAVES = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/map_port_arbiter_if.sv
// Client-side bundle of the map port arbiter: two read requesters, the edit
// port and the fill engine controls.
interface map_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
);

  // Handshake rule for every req/ready pair here: a transfer happens in exactly
  // the cycle where req and ready are both high; ready may depend on req.
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [1:0]        rd_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output rd_req, rd_addr0, rd_addr1, wr_req, wr_addr, wr_data, fill_start, fill_value,
    input  rd_ready, rsp_valid, rsp_data, wr_ready, fill_busy, fill_done
  );

  modport slave (
    input  rd_req, rd_addr0, rd_addr1, wr_req, wr_addr, wr_data, fill_start, fill_value,
    output rd_ready, rsp_valid, rsp_data, wr_ready, fill_busy, fill_done
  );

endinterface

// File: rtl/map_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins at once, a tie goes to the
// requester that was not granted last.
module map_port_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester that wins the next tie.
  logic prio;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant != 2'b00) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the map block RAM: round-robin read port for two clients, and a write
// port sequenced between single-block edits and a whole-world fill.
module map_port_arbiter
  import map_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MAP_ADDR_W,
  parameter int DATA_W     = MAP_DATA_W,
  parameter int READ_LAT   = 1,
  parameter int FILL_DEPTH = 32768
) (
  input  logic              clk,
  input  logic              rst,
  map_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] map_block_addr,
  input  logic [DATA_W-1:0] map_block_id,
  output logic [ADDR_W-1:0] map_write_addr,
  output logic [DATA_W-1:0] map_write_data,
  output logic              map_write_en,
  output fill_state_e       fsm_state
);

  // One extra bit so a fill covering the whole address space never wraps.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILL_DEPTH - 1);

  logic [1:0] grant;

  map_port_arbiter_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.rd_req),
    .grant (grant)
  );

  assign bus.rd_ready   = grant;
  assign map_block_addr = grant[1] ? bus.rd_addr1 : bus.rd_addr0;

  // Requester tag travels alongside the RAM's own read latency.
  logic [1:0] rsp_pipe [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        rsp_pipe[i] <= 2'b00;
      end
    end else begin
      rsp_pipe[0] <= grant;
      for (int i = 1; i < READ_LAT; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign bus.rsp_valid = rsp_pipe[READ_LAT-1];
  assign bus.rsp_data  = map_block_id;

  fill_state_e       state;
  fill_state_e       state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] fill_val_n;
  logic              we_n;
  logic [ADDR_W-1:0] wa_n;
  logic [DATA_W-1:0] wd_n;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    fill_val_n    = fill_val;
    we_n          = 1'b0;
    wa_n          = map_write_addr;
    wd_n          = map_write_data;
    bus.wr_ready  = 1'b0;
    bus.fill_busy = 1'b0;
    bus.fill_done = 1'b0;

    unique case (state)
      S_IDLE: begin
        // A fill request takes the write port ahead of a same-cycle edit.
        bus.wr_ready = !bus.fill_start;
        if (bus.fill_start) begin
          state_n    = S_FILL;
          cnt_n      = '0;
          fill_val_n = bus.fill_value;
        end else if (bus.wr_req) begin
          we_n = 1'b1;
          wa_n = bus.wr_addr;
          wd_n = bus.wr_data;
        end
      end
      S_FILL: begin
        bus.fill_busy = 1'b1;
        we_n          = 1'b1;
        wa_n          = cnt[ADDR_W-1:0];
        wd_n          = fill_val;
        cnt_n         = cnt + CNT_W'(1);
        if (cnt == LAST_IDX) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        bus.fill_done = 1'b1;
        state_n       = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      fill_val       <= BLK_AIR;
      map_write_en   <= 1'b0;
      map_write_addr <= '0;
      map_write_data <= BLK_AIR;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      fill_val       <= fill_val_n;
      map_write_en   <= we_n;
      map_write_addr <= wa_n;
      map_write_data <= wd_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a latency-accurate map RAM and a
// cycle-level reference model of the arbitration and write sequencing rules.
module tb_map_port_arbiter;
  import map_port_arbiter_pkg::*;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 4;
  localparam int READ_LAT   = 2;
  localparam int FILL_DEPTH = 16;
  localparam int QW         = 2 + DATA_W;
  localparam int DEPTH      = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] map_block_addr;
  logic [DATA_W-1:0] map_block_id;
  logic [ADDR_W-1:0] map_write_addr;
  logic [DATA_W-1:0] map_write_data;
  logic              map_write_en;
  fill_state_e       fsm_state;

  map_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .FILL_DEPTH(FILL_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .map_block_addr (map_block_addr),
    .map_block_id   (map_block_id),
    .map_write_addr (map_write_addr),
    .map_write_data (map_write_data),
    .map_write_en   (map_write_en),
    .fsm_state      (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] preload(input int a);
    case (a)
      'h0123:  return BLK_WATER;
      'h0010:  return BLK_STONE;
      'h0020:  return BLK_DIRT;
      default: return BLK_AIR;
    endcase
  endfunction

  // ---------------- map RAM with READ_LAT cycles of read latency ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dp  [READ_LAT];
  bit ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = preload(a);
      ram_init = 1'b1;
    end
    dp[0] <= mem[map_block_addr];
    for (int i = 1; i < READ_LAT; i++) dp[i] <= dp[i-1];
    if (map_write_en) mem[map_write_addr] = map_write_data;
  end
  assign map_block_id = dp[READ_LAT-1];

  // ---------------- reference model + per-cycle compare ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_init = 1'b0;
  logic [QW-1:0]     exp_q[$];
  int                due_q[$];
  int                fs = -1000;
  logic [DATA_W-1:0] fv = '0;
  logic              last_gnt = 1'b1;
  logic              pend_we = 1'b0;
  logic [ADDR_W-1:0] pend_a = '0;
  logic [DATA_W-1:0] pend_d = '0;
  logic [1:0]        g;
  logic [QW-1:0]     e;
  logic              ew;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] ed;
  logic [ADDR_W-1:0] ra;
  bit                in_fill, is_done, is_idle;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = preload(a);
      ref_init = 1'b1;
    end
    if (model_on) begin
      cyc++;
      in_fill = (cyc >= fs + 1) && (cyc <= fs + FILL_DEPTH);
      is_done = (cyc == fs + FILL_DEPTH + 1);
      is_idle = !(in_fill || is_done);

      case (bus.rd_req)
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = last_gnt ? 2'b01 : 2'b10;
        default: g = 2'b00;
      endcase
      ra = (g == 2'b10) ? bus.rd_addr1 : bus.rd_addr0;
      chk("m_rd_ready", 32'(bus.rd_ready), 32'(g));
      chk("m_block_addr", 32'(map_block_addr), 32'(ra));

      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(e[QW-1 -: 2]));
        chk("m_rsp_data", 32'(bus.rsp_data), 32'(e[DATA_W-1:0]));
      end else begin
        chk("m_rsp_idle", 32'(bus.rsp_valid), 32'h0);
      end

      if (cyc >= fs + 2 && cyc <= fs + FILL_DEPTH + 1) begin
        ew = 1'b1; ea = ADDR_W'(cyc - fs - 2); ed = fv;
      end else if (pend_we) begin
        ew = 1'b1; ea = pend_a; ed = pend_d;
      end else begin
        ew = 1'b0; ea = '0; ed = '0;
      end
      chk("m_write_en", 32'(map_write_en), 32'(ew));
      if (ew) begin
        chk("m_write_addr", 32'(map_write_addr), 32'(ea));
        chk("m_write_data", 32'(map_write_data), 32'(ed));
      end
      chk("m_fill_busy", 32'(bus.fill_busy), 32'(in_fill));
      chk("m_fill_done", 32'(bus.fill_done), 32'(is_done));
      chk("m_wr_ready", 32'(bus.wr_ready), 32'(is_idle && !bus.fill_start));

      // Reads see RAM contents before this cycle's write lands.
      if (g != 2'b00) begin
        exp_q.push_back({g, ref_mem[ra]});
        due_q.push_back(cyc + READ_LAT);
      end
      if (ew) ref_mem[ea] = ed;
      pend_we = bus.wr_req && is_idle && !bus.fill_start;
      pend_a  = bus.wr_addr;
      pend_d  = bus.wr_data;

      if (rst) begin
        exp_q.delete();
        due_q.delete();
        fs       = -1000;
        last_gnt = 1'b1;
        pend_we  = 1'b0;
      end else begin
        if (g != 2'b00) last_gnt = g[1];
        if (is_idle && bus.fill_start) begin
          fs = cyc;
          fv = bus.fill_value;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_run(input logic [DATA_W-1:0] v, input bit edit_same, input bit second_start);
    int nw;
    nw = 0;
    bus.fill_start = 1'b1;
    bus.fill_value = v;
    bus.wr_addr    = 15'h0055;
    bus.wr_data    = 4'd9;
    bus.wr_req     = edit_same;
    @(negedge clk);
    if (edit_same) chk("fill_beats_edit_ready", 32'(bus.wr_ready), 32'h0);
    step();
    bus.fill_start = 1'b0;
    bus.fill_value = '0;
    bus.wr_req     = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      if (second_start && j == 5) begin
        bus.fill_start = 1'b1;
        bus.fill_value = ~v;
      end
      @(negedge clk);
      if (map_write_en && map_write_data == v) nw++;
      if (j == 1)  chk("fill_busy_first", 32'(bus.fill_busy), 32'h1);
      if (j == 17) chk("fill_done_cycle17", 32'(bus.fill_done), 32'h1);
      if (j == 18) chk("edit_after_fill_ready", 32'(bus.wr_ready), 32'h1);
      if (j == 19) begin
        chk("edit_after_fill_en", 32'(map_write_en), 32'h1);
        chk("edit_after_fill_addr", 32'(map_write_addr), 32'h0055);
      end
      step();
      bus.fill_start = 1'b0;
      bus.fill_value = '0;
      if (j == 18) bus.wr_req = 1'b0;
    end
    chk("fill_write_count", 32'(nw), 32'd16);
  endtask

  int done_seen;

  initial begin
    bus.rd_req     = 2'b00;
    bus.rd_addr0   = '0;
    bus.rd_addr1   = '0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.fill_start = 1'b0;
    bus.fill_value = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_on = 1'b1;

    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_fill_busy", 32'(bus.fill_busy), 32'h0);
    chk("reset_fill_done", 32'(bus.fill_done), 32'h0);
    chk("reset_write_en", 32'(map_write_en), 32'h0);
    chk("reset_write_addr", 32'(map_write_addr), 32'h0);
    chk("reset_write_data", 32'(map_write_data), 32'h0);
    chk("reset_state", 32'(fsm_state), 32'(S_IDLE));

    // Single read from requester 0.
    step();
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 15'h0123;
    @(negedge clk);
    chk("t1_ready_same_cycle", 32'(bus.rd_ready), 32'h1);
    step();
    bus.rd_req = 2'b00;
    repeat (READ_LAT - 1) step();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(bus.rsp_data), 32'h5);

    // Requester 1 alone, then both held for four cycles.
    step();
    bus.rd_req   = 2'b10;
    bus.rd_addr1 = 15'h0020;
    @(negedge clk);
    chk("t2_lone_req1", 32'(bus.rd_ready), 32'h2);
    step();
    bus.rd_req   = 2'b11;
    bus.rd_addr0 = 15'h0010;
    for (int i = 0; i < 4 + READ_LAT; i++) begin
      @(negedge clk);
      if (i < 4) chk("t2_grant_alternates", 32'(bus.rd_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i >= READ_LAT) begin
        chk("t2_rsp_tag", 32'(bus.rsp_valid), ((i - READ_LAT) % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_rsp_data", 32'(bus.rsp_data), ((i - READ_LAT) % 2 == 0) ? 32'h1 : 32'h2);
      end
      step();
      if (i == 3) bus.rd_req = 2'b00;
    end

    // Single-block edit at the top address, then read it back.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h7FFF;
    bus.wr_data = BLK_GRASS;
    @(negedge clk);
    chk("t3_wr_ready", 32'(bus.wr_ready), 32'h1);
    step();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("t3_write_en", 32'(map_write_en), 32'h1);
    chk("t3_write_addr", 32'(map_write_addr), 32'h7FFF);
    chk("t3_write_data", 32'(map_write_data), 32'h3);
    step();
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 15'h7FFF;
    step();
    bus.rd_req = 2'b00;
    repeat (READ_LAT - 1) step();
    @(negedge clk);
    chk("t3_readback", 32'(bus.rsp_data), 32'h3);

    // Fills: plain, then with a same-cycle edit and an ignored restart.
    step();
    fill_run(BLK_LEAVES, 1'b0, 1'b0);
    fill_run(BLK_SAND, 1'b1, 1'b1);

    // Reset during fill write 8 aborts the fill.
    bus.fill_start = 1'b1;
    bus.fill_value = BLK_WOOD;
    step();
    bus.fill_start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_write8_addr", 32'(map_write_addr), 32'h8);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_abort_write_en", 32'(map_write_en), 32'h0);
    chk("t6_abort_busy", 32'(bus.fill_busy), 32'h0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      if (bus.fill_done) done_seen++;
    end
    chk("t6_no_fill_done", 32'(done_seen), 32'h0);
    step();
    bus.fill_start = 1'b1;
    bus.fill_value = BLK_WATER;
    step();
    bus.fill_start = 1'b0;
    step();
    @(negedge clk);
    chk("t6_restart_en", 32'(map_write_en), 32'h1);
    chk("t6_restart_addr", 32'(map_write_addr), 32'h0);
    chk("t6_restart_data", 32'(map_write_data), 32'h5);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
